// File: rtl/ni_be_arb_pkg.sv
// Shared types and helpers for the BE link arbiter: FSM states, round-robin pick
// and counter sizing.
package ni_be_arb_pkg;

    localparam int unsigned MAX_IN        = 8;
    localparam int unsigned PTR_W         = 3;
    localparam int unsigned MAX_LEN_LIMIT = 256;
    localparam int unsigned CNT_W_LIMIT   = $clog2(MAX_LEN_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // One-hot grant of the first requester at or after ptr, modulo n.
    function automatic logic [MAX_IN-1:0] rr_next_grant(
        input logic [MAX_IN-1:0] req,
        input logic [PTR_W-1:0]  ptr,
        input int unsigned       n
    );
        logic [MAX_IN-1:0] g;
        logic              found;
        int unsigned       idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_IN; k++) begin
            idx = (32'(ptr) + k) % n;
            if (!found && (k < n) && req[idx[PTR_W-1:0]]) begin
                g[idx[PTR_W-1:0]] = 1'b1;
                found             = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/ni_be_out_reg.sv
// Single-stage flit/last/valid output register with ready backpressure.
module ni_be_out_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_flit,
    input  logic         d_last,
    input  logic         d_valid,
    output logic [W-1:0] q_flit,
    output logic         q_last,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         free_c
);

    assign free_c = !q_valid || q_ready;

    // Contents only change while the stage is free, so a stalled flit stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_flit  <= '0;
            q_last  <= 1'b0;
            q_valid <= 1'b0;
        end else if (free_c) begin
            q_valid <= d_valid;
            if (d_valid) begin
                q_flit <= d_flit;
                q_last <= d_last;
            end
        end
    end

endmodule

// File: rtl/ni_be_link_arbiter.sv
// Packet-level round-robin arbiter sharing one BE NoC link among NUM_IN sources,
// with MAX_LEN truncation and draining of overlong packets.
module ni_be_link_arbiter
    import ni_be_arb_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned NUM_IN     = 2,
    parameter int unsigned MAX_LEN    = 8
) (
    input  logic                                clk_noc,
    input  logic                                rst_noc,
    input  logic [NUM_IN-1:0][FLIT_WIDTH-1:0]   in_flit,
    input  logic [NUM_IN-1:0]                   in_valid,
    input  logic [NUM_IN-1:0]                   in_last,
    output logic [NUM_IN-1:0]                   in_ready,
    output logic [FLIT_WIDTH-1:0]               out_flit,
    output logic                                out_valid,
    output logic                                out_last,
    input  logic                                out_ready,
    output logic [NUM_IN-1:0]                   grant,
    output logic [NUM_IN-1:0]                   err_overlen,
    input  logic                                err_clear
);

    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

    arb_state_t              state;
    logic [PTR_W-1:0]        ptr;
    logic [CNT_W-1:0]        cnt;

    logic                    stage_free_c;
    logic [MAX_IN-1:0]       pick_c;
    logic [FLIT_WIDTH-1:0]   own_flit_c;
    logic                    own_valid_c;
    logic                    own_last_c;
    logic [PTR_W-1:0]        nxt_ptr_c;
    logic                    acc_c;
    logic                    at_max_c;
    logic                    ovl_c;
    logic                    load_c;
    logic [NUM_IN-1:0]       err_set_c;

    assign pick_c = rr_next_grant(MAX_IN'(in_valid), ptr, NUM_IN);

    // Owner's inputs selected through the one-hot grant; also the rr successor.
    always_comb begin
        own_flit_c  = '0;
        own_valid_c = 1'b0;
        own_last_c  = 1'b0;
        nxt_ptr_c   = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                own_flit_c  = own_flit_c | in_flit[i];
                own_valid_c = own_valid_c | in_valid[i];
                own_last_c  = own_last_c | in_last[i];
                nxt_ptr_c   = (i == NUM_IN - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    assign in_ready  = (state == FWD)   ? (grant & {NUM_IN{stage_free_c}}) :
                       (state == DRAIN) ? grant : '0;
    assign acc_c     = own_valid_c && (|in_ready);
    assign at_max_c  = (cnt == CNT_W'(MAX_LEN - 1));
    assign load_c    = (state == FWD) && acc_c;
    assign ovl_c     = load_c && !own_last_c && at_max_c;
    assign err_set_c = grant & {NUM_IN{ovl_c}};

    ni_be_out_reg #(
        .W (FLIT_WIDTH)
    ) u_out_reg (
        .clk     (clk_noc),
        .rst_n   (rst_noc),
        .d_flit  (own_flit_c),
        .d_last  (own_last_c || ovl_c),
        .d_valid (load_c),
        .q_flit  (out_flit),
        .q_last  (out_last),
        .q_valid (out_valid),
        .q_ready (out_ready),
        .free_c  (stage_free_c)
    );

    // Arbitration FSM; the grant is held until the owner's last flit is taken.
    always_ff @(posedge clk_noc or negedge rst_noc) begin
        if (!rst_noc) begin
            state       <= IDLE;
            grant       <= '0;
            ptr         <= '0;
            cnt         <= '0;
            err_overlen <= '0;
        end else begin
            err_overlen <= (err_overlen & ~{NUM_IN{err_clear}}) | err_set_c;
            case (state)
                IDLE: begin
                    if (|in_valid) begin
                        grant <= pick_c[NUM_IN-1:0];
                        cnt   <= '0;
                        state <= FWD;
                    end
                end
                FWD: begin
                    if (acc_c) begin
                        if (own_last_c) begin
                            state <= IDLE;
                            grant <= '0;
                            ptr   <= nxt_ptr_c;
                            cnt   <= '0;
                        end else if (at_max_c) begin
                            state <= DRAIN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (acc_c && own_last_c) begin
                        state <= IDLE;
                        grant <= '0;
                        ptr   <= nxt_ptr_c;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ni_be_link_arbiter.sv
// Scoreboard bench for ni_be_link_arbiter: directed packets, expected flits and
// grants queued up front, a negedge monitor pops and compares.
module tb_ni_be_link_arbiter;

    localparam int unsigned FW = 32;
    localparam int unsigned NI = 2;
    localparam int unsigned ML = 8;

    typedef struct packed {
        logic [FW-1:0] flit;
        logic          last;
    } exp_t;

    logic                      clk_noc = 1'b0;
    logic                      rst_noc;
    logic [NI-1:0][FW-1:0]     in_flit;
    logic [NI-1:0]             in_valid;
    logic [NI-1:0]             in_last;
    logic [NI-1:0]             in_ready;
    logic [FW-1:0]             out_flit;
    logic                      out_valid;
    logic                      out_last;
    logic                      out_ready;
    logic [NI-1:0]             grant;
    logic [NI-1:0]             err_overlen;
    logic                      err_clear;

    exp_t          exp_q[$];
    logic [NI-1:0] eg_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          bp_done;
    logic [3:0]    pat = 4'b1001;

    ni_be_link_arbiter #(
        .FLIT_WIDTH (FW),
        .NUM_IN     (NI),
        .MAX_LEN    (ML)
    ) dut (
        .clk_noc     (clk_noc),
        .rst_noc     (rst_noc),
        .in_flit     (in_flit),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_flit    (out_flit),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .grant       (grant),
        .err_overlen (err_overlen),
        .err_clear   (err_clear)
    );

    always #5 clk_noc = ~clk_noc;

    function automatic logic [FW-1:0] mk(input int s, input int p, input int i);
        return {8'(s), 8'(p), 16'(i)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected output of one packet: truncated to ML flits, last forced on the final one.
    task automatic push_pkt(input int s, input int p, input int n);
        int            m;
        logic [NI-1:0] g;
        exp_t          e;
        m = (n > int'(ML)) ? int'(ML) : n;
        for (int i = 0; i < m; i++) begin
            e.flit = mk(s, p, i);
            e.last = (i == m - 1);
            exp_q.push_back(e);
        end
        g    = '0;
        g[s] = 1'b1;
        eg_q.push_back(g);
    endtask

    task automatic send_pkt(input int s, input int p, input int n, input int clr_idx);
        logic ok;
        for (int i = 0; i < n; i++) begin
            in_flit[s]  = mk(s, p, i);
            in_last[s]  = (i == n - 1);
            in_valid[s] = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 300 && !ok; t++) begin
                @(negedge clk_noc);
                ok = in_ready[s];
            end
            if (!ok) begin
                n_cmp++;
                n_bad++;
                $display("FAIL src%0d_accept_timeout: got no in_ready required in_ready pkt %0d flit %0d", s, p, i);
            end
            if (ok && i == clr_idx) err_clear = 1'b1;
            @(posedge clk_noc);
            #1;
            if (i == clr_idx) err_clear = 1'b0;
        end
        in_valid[s] = 1'b0;
        in_last[s]  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || eg_q.size() != 0) && t < 1000) begin
            @(negedge clk_noc);
            t++;
        end
        if (t >= 1000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d flits %0d grants pending required 0", exp_q.size(), eg_q.size());
        end
        repeat (2) @(negedge clk_noc);
    endtask

    // Monitor: output transfers, stall stability and each new grant.
    logic          stalled = 1'b0;
    logic [FW-1:0] held_f;
    logic          held_l;
    logic [NI-1:0] prev_g = '0;
    exp_t          e_m;
    logic [NI-1:0] g_m;

    always @(negedge clk_noc) begin
        if (!rst_noc) begin
            stalled = 1'b0;
            prev_g  = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %0h required no flit", out_flit);
                end else begin
                    e_m = exp_q.pop_front();
                    check("out_flit", out_flit, e_m.flit);
                    check("out_last", 32'(out_last), 32'(e_m.last));
                end
            end
            if (out_valid && stalled) begin
                check("stall_flit", out_flit, held_f);
                check("stall_last", 32'(out_last), 32'(held_l));
            end
            stalled = out_valid && !out_ready;
            held_f  = out_flit;
            held_l  = out_last;
            if (grant != '0 && prev_g == '0) begin
                if (eg_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_grant: got %0b required none", grant);
                end else begin
                    g_m = eg_q.pop_front();
                    check("grant", 32'(grant), 32'(g_m));
                end
            end
            prev_g = grant;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_noc   = 1'b0;
        in_flit   = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b1;
        err_clear = 1'b0;
        bp_done   = 1'b0;
        #12;
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_flit", out_flit, 32'(0));
        check("rst_err", 32'(err_overlen), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        @(negedge clk_noc);
        rst_noc = 1'b1;

        // Contention: alternating owners, 3-flit packets.
        push_pkt(0, 1, 3);
        push_pkt(1, 2, 3);
        push_pkt(0, 3, 3);
        push_pkt(1, 4, 3);
        fork
            begin send_pkt(0, 1, 3, -1); send_pkt(0, 3, 3, -1); end
            begin send_pkt(1, 2, 3, -1); send_pkt(1, 4, 3, -1); end
        join
        wait_drain();

        // Backpressure on a 4-flit packet from src1.
        push_pkt(1, 5, 4);
        bp_done = 1'b0;
        fork
            begin send_pkt(1, 5, 4, -1); bp_done = 1'b1; end
            begin
                for (int k = 0; k < 400 && !bp_done; k++) begin
                    out_ready = pat[k % 4];
                    @(posedge clk_noc);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        // Overlength from src0 while src1 waits.
        push_pkt(0, 6, 11);
        push_pkt(1, 7, 2);
        fork
            send_pkt(0, 6, 11, -1);
            send_pkt(1, 7, 2, -1);
        join
        wait_drain();
        check("err_after_ovl", 32'(err_overlen), 32'(2'b01));
        @(posedge clk_noc); #1; err_clear = 1'b1;
        @(posedge clk_noc); #1; err_clear = 1'b0;
        check("err_after_clear", 32'(err_overlen), 32'(0));

        // Exactly MAX_LEN flits, then single-flit packets.
        push_pkt(0, 8, 8);
        send_pkt(0, 8, 8, -1);
        wait_drain();
        check("err_exact_len", 32'(err_overlen), 32'(0));
        push_pkt(0, 9, 1);
        send_pkt(0, 9, 1, -1);
        wait_drain();
        push_pkt(1, 10, 1);
        push_pkt(0, 11, 1);
        fork
            send_pkt(0, 11, 1, -1);
            send_pkt(1, 10, 1, -1);
        join
        wait_drain();

        // Overlength event coinciding with err_clear.
        push_pkt(1, 12, 9);
        send_pkt(1, 12, 9, 7);
        wait_drain();
        check("err_set_wins", 32'(err_overlen), 32'(2'b10));
        @(posedge clk_noc); #1; err_clear = 1'b1;
        @(posedge clk_noc); #1; err_clear = 1'b0;
        check("err_clear2", 32'(err_overlen), 32'(0));

        // Reset mid-packet with the rr pointer moved off source 0.
        push_pkt(0, 13, 1);
        send_pkt(0, 13, 1, -1);
        wait_drain();
        begin
            exp_t          e;
            logic [NI-1:0] g;
            e.flit = mk(0, 14, 0);
            e.last = 1'b0;
            exp_q.push_back(e);
            g = 2'b01;
            eg_q.push_back(g);
        end
        in_flit[0]  = mk(0, 14, 0);
        in_last[0]  = 1'b0;
        in_valid[0] = 1'b1;
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk_noc);
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        #2;
        rst_noc = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'(0));
        check("async_rst_grant", 32'(grant), 32'(0));
        check("async_rst_in_ready", 32'(in_ready), 32'(0));
        in_valid = '0;
        in_last  = '0;
        repeat (2) @(negedge clk_noc);
        rst_noc = 1'b1;
        push_pkt(0, 15, 1);
        push_pkt(1, 16, 1);
        fork
            send_pkt(0, 15, 1, -1);
            send_pkt(1, 16, 1, -1);
        join
        wait_drain();

        check("leftover_flits", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ni_be_link_arbiter.md
Name: ni_be_link_arbiter

Overview:
- Packet-level round-robin arbiter that shares one BE NoC output link between NUM_IN BE sources, e.g. several BE endpoints or an endpoint plus a debug injector.
- Sits between the BE endpoint outputs and the router-facing noc_out_* of one CT link, in the NoC clock domain.
- Holds the grant for a whole packet and registers the output (1 pipeline stage).
- Enforces MAX_LEN: an overlong packet is truncated and its remainder drained.

Parameters:
- FLIT_WIDTH, 32, flit width in bits.
- NUM_IN, 2, number of requesting BE sources (2..8).
- MAX_LEN, 8, maximum flits per packet including header (2..256).

Ports:
- clk_noc  in  1  NoC clock.
- rst_noc  in  1  reset, asynchronous, active-low.
- in_flit  in  [NUM_IN][FLIT_WIDTH]  source flits.
- in_valid  in  [NUM_IN]  source flit valid.
- in_last  in  [NUM_IN]  source last flit of packet.
- in_ready  out  [NUM_IN]  source flit accepted.
- out_flit  out  FLIT_WIDTH  flit to link.
- out_valid  out  1  output valid.
- out_last  out  1  output last.
- out_ready  in  1  link accepts.
- grant  out  [NUM_IN]  one-hot current owner, 0 when idle.
- err_overlen  out  [NUM_IN]  sticky per-source overlength flag.
- err_clear  in  1  clears err_overlen; set wins over clear in the same cycle.

Behaviour:
- Reset (rst_noc low, async): state IDLE, grant=0, out_valid=0, out_flit=0, out_last=0, rr pointer=0 (source 0 highest priority), flit counter=0, err_overlen=0, in_ready=0.
- Output register: loads when out_valid=0 or out_ready=1 (stage free). out_* are held stable while out_valid=1 and out_ready=0.
- Input accept: in_ready[i] = (grant[i] and stage free) in FWD; 1 for the drained source in DRAIN.
- Handshake: a flit transfers on in_valid & in_ready. Output latency is exactly 1 cycle. Full throughput is 1 flit/cycle when out_ready=1.
- IDLE: if any in_valid, grant the first requester at or after the rr pointer (modulo NUM_IN), then go to FWD. Grant is registered, so the first flit is accepted the cycle after the grant. The arbitration cycle is a 1-cycle bubble per packet.
- FWD:
  - Each accepted flit increments the counter and is registered with its in_last.
  - Accepted flit with in_last=1: go to IDLE, rr pointer = granted index + 1 (wrap at NUM_IN), counter=0, grant=0.
  - Accepted flit number MAX_LEN with in_last=0: force out_last=1, set err_overlen[owner], go to DRAIN (grant stays on owner), counter=0.
- DRAIN: the owner's flits are accepted and discarded (nothing loaded into the output stage) until a flit with in_last=1 is accepted. Then go to IDLE and advance the rr pointer as above.
- Non-granted sources: in_ready=0. A source's in_valid dropping mid-packet does not release the grant; the arbiter waits, because packets are atomic on the link.
- Counter: $clog2(MAX_LEN+1) bits, never wraps. A packet of exactly MAX_LEN flits with last on flit MAX_LEN is legal, not an error.
- A single-flit packet (in_last on the header) is legal.
- An output stall never drops or duplicates a flit. The grant is held across the stall.

Decomposition:
- Package ni_be_arb_pkg: state enum {IDLE, FWD, DRAIN}, a function computing the rr next-grant one-hot from a request vector and pointer, and a localparam for the counter width.
- Sub-module ni_be_out_reg: the single-stage output register (flit/last/valid with ready), reusable on other BE paths.

Test Plan:
- Reset mid-packet: assert rst_noc low while out_valid=1 -> out_valid=0, grant=0 immediately (async). After release, source 0 wins first.
- Contention: both sources send 3-flit packets continuously with out_ready=1 -> output order is src0, src1, src0, src1. Each packet is contiguous with one bubble between packets. grant alternates 01,10.
- Backpressure: a 4-flit packet from src1 with out_ready toggling 1,0,0,1… -> all 4 flits arrive in order with no duplicates. out_flit is stable while stalled. The last flit carries out_last.
- Overlength: MAX_LEN=8, src0 sends 11 flits, last on the 11th -> 8 flits on output, the 8th with out_last=1. Flits 9-11 are consumed with nothing on the output. err_overlen=01. Then src1 is granted. err_clear -> 00.
- Boundary: a packet of exactly 8 flits -> no error. A 1-flit packet -> passes with out_last=1 and the rr pointer advances.
- Set/clear collision: an overlength event on the same cycle as err_clear -> err_overlen bit remains 1.
